vu_frame_scheduler: RTL

//   Frame-rate controller between the audio level path and the vga renderer.

---
 rtl/vu_frame_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vu_frame_scheduler.sv
// ----------------------------------------------------------------------------
// vu_frame_scheduler
//   Frame-rate controller between the audio level path and the VGA renderer.
//
//   Behaviour:
//   - During a video frame it keeps the maximum of all accepted level samples.
//   - At each vertical-blank start it runs the bar decay and the peak
//     hold/decay.
//   - It then publishes bar_level / peak_level. Both stay constant for the
//     whole following frame, so the display never tears.
//
// Ports
//   pixel_clock   in   1   single clock, rising edge
//   reset         in   1   asynchronous, active-low; clears all state
//   level_in      in   LW  audio level sample
//   level_valid   in   1   level_in valid this cycle
//   level_ready   out  1   sample accepted when level_valid & level_ready
//   vblank_start  in   1   1-cycle pulse at the first line of vertical blank
//   bar_level     out  LW  displayed bar height, 0..MAX_LEVEL
//   peak_level    out  LW  displayed peak marker, bar_level..MAX_LEVEL
//   disp_update   out  1   1-cycle pulse: new bar/peak values visible this cycle
// ----------------------------------------------------------------------------
module vu_frame_scheduler #(
   parameter int LW          = 8,
   parameter int MAX_LEVEL   = 200,
   parameter int DECAY       = 2,
   parameter int PEAK_DECAY  = 1,
   parameter int HOLD_FRAMES = 30,
   parameter int HW          = 5
) (
   input  logic          pixel_clock,
   input  logic          reset,
   input  logic [LW-1:0] level_in,
   input  logic          level_valid,
   output logic          level_ready,
   input  logic          vblank_start,
   output logic [LW-1:0] bar_level,
   output logic [LW-1:0] peak_level,
   output logic          disp_update
);

   localparam logic [LW-1:0] MAX_W   = LW'(MAX_LEVEL);
   localparam logic [LW-1:0] DECAY_W = LW'(DECAY);
   localparam logic [LW-1:0] PDEC_W  = LW'(PEAK_DECAY);
   localparam logic [HW-1:0] HOLD_W  = HW'(HOLD_FRAMES);

   typedef enum logic [1:0] {ACCUM, COMMIT, PEAK} state_t;

   state_t        state, state_nxt;
   logic [LW-1:0] frame_max, snap, bar_n;
   logic [HW-1:0] hold_cnt;

   logic          accept;
   logic [LW-1:0] s_clamp, s_acc, max_in;
   logic [LW-1:0] bar_calc, peak_sel, peak_final;
   logic [HW-1:0] hold_nxt;

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge pixel_clock or negedge reset) begin
      // NOTE: registers use non-blocking assignments, so every flop samples
      // the values from before the edge, whatever order the statements are in.
      if (!reset) state <= ACCUM;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: each output gets a default before the case. Without it, a path
      // that leaves a signal unassigned would infer a latch.
      state_nxt   = state;
      level_ready = 1'b0;
      case (state)
         ACCUM: begin
            level_ready = 1'b1;
            if (vblank_start) state_nxt = COMMIT;
         end
         COMMIT:  state_nxt = PEAK;
         PEAK:    state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // ----------------------------------------------------------- datapath ---
   always_comb begin
      accept  = level_valid & level_ready;
      s_clamp = (level_in > MAX_W) ? MAX_W : level_in;
      s_acc   = accept ? s_clamp : '0;
      max_in  = (s_acc > frame_max) ? s_acc : frame_max;

      // The bar jumps up to any louder frame. Otherwise it falls by DECAY
      // and stops at 0.
      bar_calc = (snap >= bar_level) ? snap
               : bar_level - ((bar_level < DECAY_W) ? bar_level : DECAY_W);

      hold_nxt = hold_cnt;
      if (snap >= peak_level) begin
         peak_sel = snap;
         hold_nxt = HOLD_W;
      end else if (hold_cnt != '0) begin
         peak_sel = peak_level;
         hold_nxt = hold_cnt - 1'b1;
      end else begin
         peak_sel = peak_level - ((peak_level < PDEC_W) ? peak_level : PDEC_W);
      end
      // The marker may never sit below the bar it annotates.
      peak_final = (peak_sel >= bar_n) ? peak_sel : bar_n;
   end

   always_ff @(posedge pixel_clock or negedge reset) begin
      // NOTE: every register here is a plain flop with an async clear.
      // There is no memory array, so there is nothing that must stay out of
      // the reset.
      if (!reset) begin
         frame_max   <= '0;
         snap        <= '0;
         bar_n       <= '0;
         bar_level   <= '0;
         peak_level  <= '0;
         hold_cnt    <= '0;
         disp_update <= 1'b0;
      end else begin
         disp_update <= (state == PEAK);
         case (state)
            ACCUM: begin
               if (vblank_start) begin
                  // A sample taken in the vblank cycle still belongs to the
                  // closing frame.
                  snap      <= max_in;
                  frame_max <= '0;
               end else if (accept) begin
                  frame_max <= max_in;
               end
            end
            COMMIT: bar_n <= bar_calc;
            PEAK: begin
               bar_level  <= bar_n;
               peak_level <= peak_final;
               hold_cnt   <= hold_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule
